// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the boot-time instruction memory loader:
//   frame geometry constants, the 3-bit FSM state encoding and small
//   helpers that classify states.
package imem_loader_pkg;

  // Length header is two bytes, big-endian.
  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;
  // Each instruction word arrives as four bytes, MSB first.
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // States in which the loader is actively working on a frame.
  function automatic logic is_busy(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_WRITE);
  endfunction

  // States in which a stream byte can be accepted.
  function automatic logic is_receiving(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler
//   Packs a byte stream into 32-bit words, first byte into bits [31:24].
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clr         clear the shift register and byte counter
//     shift       accept din this cycle
//     din[7:0]    stream byte
//     word[31:0]  word contents including the byte shifted this cycle
//     full        this cycle's shift completes a word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state shift register and byte count; the counter wraps to zero
  // once a word is complete, so no explicit clear is needed between words.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift) begin
      word_d = {word_q[23:0], din};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Exposing the next value lets the loader capture a finished word on
  // the same edge that accepts its last byte.
  assign word = word_d;
  assign full = shift & ~clr & (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Receives a valid/ready byte stream holding a
//   16-bit big-endian word count N followed by 4*N big-endian instruction
//   bytes, writes each word into instruction memory and holds the CPU in
//   reset until the whole image is in place.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     start           one-cycle pulse starting a load (ignored while busy)
//     in_data/valid   stream byte and its valid
//     in_ready        loader accepts a byte this cycle
//     im_we           one-cycle IM write strobe per word
//     im_addr         IM word index of the write
//     im_baddr        byte address of im_addr (TEXT_BASE + 4*im_addr)
//     im_wdata        instruction word being written
//     cpu_rst         CPU reset request, low only once the image is loaded
//     busy            frame in progress
//     done            image fully written (level until next start)
//     err             header length exceeds IM depth (level until next start)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_baddr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // One extra bit so that a full-depth image (N == 2**ADDR_WIDTH) and the
  // final word_idx+1 comparison never overflow.
  localparam int              IDX_W = LEN_W + 1;
  localparam logic [IDX_W-1:0] DEPTH = IDX_W'(1) << ADDR_WIDTH;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        n_q, n_d;
  logic [IDX_W-1:0]        word_idx_q, word_idx_d;
  logic                    in_ready_q, in_ready_d;
  logic                    im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0]   im_addr_q, im_addr_d;
  logic [31:0]             im_wdata_q, im_wdata_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    xfer;
  logic [LEN_W-1:0]        n_len;
  logic                    asm_clr;
  logic                    asm_shift;
  logic [31:0]             asm_word;
  logic                    asm_full;

  assign xfer  = in_valid & in_ready_q;
  assign n_len = {n_q[LEN_W-1:8], in_data};

  word_assembler u_asm (
    .clk   (clk),
    .rst   (rst),
    .clr   (asm_clr),
    .shift (asm_shift),
    .din   (in_data),
    .word  (asm_word),
    .full  (asm_full)
  );

  // Next-state logic. Outputs are derived from the next state so that the
  // registered outputs always describe the state being entered.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    asm_clr    = 1'b0;
    asm_shift  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          word_idx_d = '0;
          asm_clr    = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          n_d     = {in_data, n_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          n_d = n_len;
          if (n_len == '0) begin
            state_d = ST_DONE;
          end else if ({1'b0, n_len} > DEPTH) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          asm_shift = 1'b1;
          if (asm_full) begin
            state_d    = ST_WRITE;
            im_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
            im_wdata_d = asm_word;
          end
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if ((word_idx_q + IDX_W'(1)) < {1'b0, n_q}) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = is_receiving(state_d);
    im_we_d    = (state_d == ST_WRITE);
    cpu_rst_d  = (state_d != ST_DONE);
    busy_d     = is_busy(state_d);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  // All loader state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign im_baddr = TEXT_BASE + {{(32 - ADDR_WIDTH - 2){1'b0}}, im_addr_q, 2'b00};
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Drives framed images into imem_loader (16-word instruction memory) and
//   compares every IM write against a queue of expected (address, word)
//   pairs produced from the image contents, plus status and latency checks
//   around each frame.
module tb_imem_loader;

  localparam int          AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_baddr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  wr_t         mon_e;
  int          last_addr;
  logic [31:0] last_data;

  imem_loader #(
    .ADDR_WIDTH (AW),
    .TEXT_BASE  (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_baddr (im_baddr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write is matched against the next expected pair; between
  // writes the address/data outputs must hold the last written values.
  initial begin
    last_addr = 0;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        last_addr = 0;
        last_data = '0;
      end else if (im_we === 1'b1) begin
        checkOutput("we_ready_low", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: addr %0d data 0x%08h, required no write", im_addr, im_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("im_addr", 32'(im_addr), 32'(mon_e.addr));
          checkOutput("im_baddr", im_baddr, BASE + 32'(4 * mon_e.addr));
          checkOutput("im_wdata", im_wdata, mon_e.data);
          last_addr = mon_e.addr;
          last_data = mon_e.data;
        end
      end else begin
        checkOutput("hold_addr", 32'(im_addr), 32'(last_addr));
        checkOutput("hold_data", im_wdata, last_data);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_im_we"},    32'(im_we),    32'd0);
    checkOutput({tag, "_im_addr"},  32'(im_addr),  32'd0);
    checkOutput({tag, "_im_wdata"}, im_wdata,      32'd0);
    checkOutput({tag, "_im_baddr"}, im_baddr,      BASE);
    checkOutput({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_done"},     32'(done),     32'd0);
    checkOutput({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after an optional idle gap; returns just after the
  // clock edge on which it was accepted.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int guard;
    for (int i = 0; i < gap; i++) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL byte_timeout: in_ready=%b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic fillImage(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // Loads img[0..n-1] as one frame. mid_start >= 0 pulses start before that
  // data byte; abort_after >= 0 pulses rst after that many data bytes.
  task automatic applyStimulus(input int n, input int max_gap, input int mid_start, input int abort_after);
    logic [15:0] nn;
    logic [31:0] w;
    int          nbytes;
    nn = 16'(n);
    pulseStart();
    checkOutput("start_busy",    32'(busy),     32'd1);
    checkOutput("start_ready",   32'(in_ready), 32'd1);
    checkOutput("start_cpu_rst", 32'(cpu_rst),  32'd1);
    checkOutput("start_done",    32'(done),     32'd0);
    checkOutput("start_err",     32'(err),      32'd0);

    nbytes = (n >= 1 && n <= DEPTH) ? 4 * n : 0;
    if (abort_after >= 0 && abort_after < nbytes) nbytes = abort_after;
    for (int i = 0; i < nbytes / 4; i++) exp_q.push_back('{i, img[i]});

    sendByte(nn[15:8], $urandom_range(max_gap, 0));
    sendByte(nn[7:0],  $urandom_range(max_gap, 0));
    for (int k = 0; k < nbytes; k++) begin
      if (k == mid_start) begin
        pulseStart();
        checkOutput("ignored_start_busy",  32'(busy),     32'd1);
        checkOutput("ignored_start_ready", 32'(in_ready), 32'd1);
        checkOutput("ignored_start_rst",   32'(cpu_rst),  32'd1);
      end
      w = img[k / 4];
      sendByte(w[31 - 8 * (k % 4) -: 8], $urandom_range(max_gap, 0));
    end

    if (abort_after >= 0) begin
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkReset("abort");
      @(negedge clk);
      #2 rst = 1'b0;
    end else if (n == 0) begin
      @(negedge clk);
      checkOutput("empty_done",    32'(done),    32'd1);
      checkOutput("empty_cpu_rst", 32'(cpu_rst), 32'd0);
      checkOutput("empty_busy",    32'(busy),    32'd0);
    end else if (n > DEPTH) begin
      @(negedge clk);
      checkOutput("over_err",     32'(err),      32'd1);
      checkOutput("over_cpu_rst", 32'(cpu_rst),  32'd1);
      checkOutput("over_ready",   32'(in_ready), 32'd0);
      checkOutput("over_done",    32'(done),     32'd0);
      checkOutput("over_busy",    32'(busy),     32'd0);
      repeat (3) @(negedge clk);
      checkOutput("over_ready_later", 32'(in_ready), 32'd0);
    end else begin
      @(negedge clk);
      checkOutput("tail_we",       32'(im_we),   32'd1);
      checkOutput("tail_cpu_rst1", 32'(cpu_rst), 32'd1);
      checkOutput("tail_done0",    32'(done),    32'd0);
      @(negedge clk);
      checkOutput("tail_done1",    32'(done),    32'd1);
      checkOutput("tail_cpu_rst0", 32'(cpu_rst), 32'd0);
      checkOutput("tail_busy",     32'(busy),    32'd0);
      checkOutput("tail_err",      32'(err),     32'd0);
    end
    checkOutput("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    checkReset("por");
    #2 rst = 1'b0;

    // Two-word program from the boot example.
    img = '{32'h2008_0005, 32'hAC08_0050};
    applyStimulus(2, 0, -1, -1);

    // Empty image.
    applyStimulus(0, 0, -1, -1);

    // One word too many, then exactly full depth.
    fillImage(DEPTH + 1);
    applyStimulus(DEPTH + 1, 0, -1, -1);
    fillImage(DEPTH);
    applyStimulus(DEPTH, 0, -1, -1);
    checkOutput("full_last_addr", 32'(im_addr), 32'(DEPTH - 1));

    // Same three-word image without and with random valid gaps.
    fillImage(3);
    applyStimulus(3, 0, -1, -1);
    applyStimulus(3, 5, -1, -1);

    // Reset after the sixth byte, then a clean reload.
    img = '{32'h2008_0005, 32'hAC08_0050};
    applyStimulus(2, 0, -1, 4);
    applyStimulus(2, 0, -1, -1);

    // Start pulsed mid-frame is ignored.
    fillImage(2);
    applyStimulus(2, 0, 2, -1);
    applyStimulus(0, 0, -1, -1);

    // Random-length images with short gaps.
    repeat (4) begin
      n = $urandom_range(DEPTH, 1);
      fillImage(n);
      applyStimulus(n, 2, -1, -1);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
